// File: rtl/fpu_out_pkg.sv
// Shared types and constants for the FPU result return queue toward the CPX.
package fpu_out_pkg;

    localparam int unsigned OQ_DEPTH_DEFAULT = 4;

    localparam int unsigned ID_W    = 5;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned EXC_W   = 5;
    localparam int unsigned FCC_W   = 2;
    localparam int unsigned ENTRY_W = ID_W + DATA_W + EXC_W + FCC_W;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [EXC_W-1:0]  exc;
        logic [FCC_W-1:0]  fcc;
    } oq_entry_t;

    typedef enum logic [1:0] {
        SelNone = 2'd0,
        SelAdd  = 2'd1,
        SelMul  = 2'd2,
        SelDiv  = 2'd3
    } pipe_sel_e;

    // Fixed priority: div beats mul beats add.
    function automatic pipe_sel_e pick_pipe(input logic add_vld, input logic mul_vld,
                                            input logic div_vld);
        if (div_vld) begin
            return SelDiv;
        end else if (mul_vld) begin
            return SelMul;
        end else if (add_vld) begin
            return SelAdd;
        end
        return SelNone;
    endfunction

endpackage

// File: rtl/fpu_out_fifo.sv
// Circular result buffer: storage, wrapping pointers and occupancy count.
module fpu_out_fifo
    import fpu_out_pkg::*;
#(
    parameter int unsigned DEPTH = OQ_DEPTH_DEFAULT,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  oq_entry_t        push_entry_i,
    input  logic             pop_i,
    output oq_entry_t        head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o
);

    oq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Contents are not reset; validity lives entirely in count_q.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fpu_out_q.sv
// FPU output queue: arbitrates add/mul/div results into a FIFO and returns them over CPX.
module fpu_out_q
    import fpu_out_pkg::*;
#(
    parameter int unsigned OQ_DEPTH = OQ_DEPTH_DEFAULT
) (
    input  logic              rclk,
    input  logic              reset,

    input  logic              add_res_vld,
    input  logic [ID_W-1:0]   add_res_id,
    input  logic [DATA_W-1:0] add_res_data,
    input  logic [EXC_W-1:0]  add_res_exc,
    input  logic [FCC_W-1:0]  add_res_fcc,
    output logic              add_res_stall,

    input  logic              mul_res_vld,
    input  logic [ID_W-1:0]   mul_res_id,
    input  logic [DATA_W-1:0] mul_res_data,
    input  logic [EXC_W-1:0]  mul_res_exc,
    input  logic [FCC_W-1:0]  mul_res_fcc,
    output logic              mul_res_stall,

    input  logic              div_res_vld,
    input  logic [ID_W-1:0]   div_res_id,
    input  logic [DATA_W-1:0] div_res_data,
    input  logic [EXC_W-1:0]  div_res_exc,
    input  logic [FCC_W-1:0]  div_res_fcc,
    output logic              div_res_stall,

    output logic              fpu_cpx_req,
    input  logic              cpx_fpu_grant,
    output logic              fpu_cpx_vld,
    output logic [ID_W-1:0]   fpu_cpx_id,
    output logic [DATA_W-1:0] fpu_cpx_data,
    output logic [EXC_W-1:0]  fpu_cpx_exc,
    output logic [FCC_W-1:0]  fpu_cpx_fcc
);

    localparam int unsigned CNT_W = $clog2(OQ_DEPTH) + 1;

    oq_entry_t        add_entry, mul_entry, div_entry, win_entry;
    oq_entry_t        oq_head;
    logic [CNT_W-1:0] oq_count;
    logic             oq_full;
    pipe_sel_e        sel;
    logic             push, pop;

    logic             cpx_vld_q;
    oq_entry_t        cpx_pkt_q;

    assign add_entry = '{id: add_res_id, data: add_res_data, exc: add_res_exc, fcc: add_res_fcc};
    assign mul_entry = '{id: mul_res_id, data: mul_res_data, exc: mul_res_exc, fcc: mul_res_fcc};
    assign div_entry = '{id: div_res_id, data: div_res_data, exc: div_res_exc, fcc: div_res_fcc};

    // Stalls depend only on vld and registered occupancy, never on the grant.
    always_comb begin
        sel       = pick_pipe(add_res_vld, mul_res_vld, div_res_vld);
        win_entry = add_entry;
        unique case (sel)
            SelDiv:  win_entry = div_entry;
            SelMul:  win_entry = mul_entry;
            default: win_entry = add_entry;
        endcase

        push = (sel != SelNone) && !oq_full && !reset;
        pop  = cpx_fpu_grant && (oq_count != '0) && !reset;

        add_res_stall = reset | (add_res_vld & ~(push & (sel == SelAdd)));
        mul_res_stall = reset | (mul_res_vld & ~(push & (sel == SelMul)));
        div_res_stall = reset | (div_res_vld & ~(push & (sel == SelDiv)));
    end

    fpu_out_fifo #(
        .DEPTH (OQ_DEPTH)
    ) u_fifo (
        .clk_i        (rclk),
        .reset_i      (reset),
        .push_i       (push),
        .push_entry_i (win_entry),
        .pop_i        (pop),
        .head_o       (oq_head),
        .count_o      (oq_count),
        .full_o       (oq_full)
    );

    // Packet fields hold between pops; only fpu_cpx_vld qualifies them.
    always_ff @(posedge rclk) begin
        if (reset) begin
            cpx_vld_q <= 1'b0;
            cpx_pkt_q <= '0;
        end else begin
            cpx_vld_q <= pop;
            if (pop) begin
                cpx_pkt_q <= oq_head;
            end
        end
    end

    assign fpu_cpx_req  = (oq_count != '0);
    assign fpu_cpx_vld  = cpx_vld_q;
    assign fpu_cpx_id   = cpx_pkt_q.id;
    assign fpu_cpx_data = cpx_pkt_q.data;
    assign fpu_cpx_exc  = cpx_pkt_q.exc;
    assign fpu_cpx_fcc  = cpx_pkt_q.fcc;

endmodule

// File: tb/tb_fpu_out_q.sv
// Directed per-cycle vector bench for fpu_out_q with hand-computed expectations.
module tb_fpu_out_q;
    import fpu_out_pkg::*;

    logic        rclk = 1'b0;
    logic        reset;
    logic        add_res_vld, mul_res_vld, div_res_vld;
    logic [4:0]  add_res_id, mul_res_id, div_res_id;
    logic [63:0] add_res_data, mul_res_data, div_res_data;
    logic [4:0]  add_res_exc, mul_res_exc, div_res_exc;
    logic [1:0]  add_res_fcc, mul_res_fcc, div_res_fcc;
    logic        add_res_stall, mul_res_stall, div_res_stall;
    logic        fpu_cpx_req, cpx_fpu_grant, fpu_cpx_vld;
    logic [4:0]  fpu_cpx_id;
    logic [63:0] fpu_cpx_data;
    logic [4:0]  fpu_cpx_exc;
    logic [1:0]  fpu_cpx_fcc;

    int checks   = 0;
    int failures = 0;

    always #5 rclk = ~rclk;

    fpu_out_q #(
        .OQ_DEPTH (4)
    ) dut (
        .rclk          (rclk),
        .reset         (reset),
        .add_res_vld   (add_res_vld),
        .add_res_id    (add_res_id),
        .add_res_data  (add_res_data),
        .add_res_exc   (add_res_exc),
        .add_res_fcc   (add_res_fcc),
        .add_res_stall (add_res_stall),
        .mul_res_vld   (mul_res_vld),
        .mul_res_id    (mul_res_id),
        .mul_res_data  (mul_res_data),
        .mul_res_exc   (mul_res_exc),
        .mul_res_fcc   (mul_res_fcc),
        .mul_res_stall (mul_res_stall),
        .div_res_vld   (div_res_vld),
        .div_res_id    (div_res_id),
        .div_res_data  (div_res_data),
        .div_res_exc   (div_res_exc),
        .div_res_fcc   (div_res_fcc),
        .div_res_stall (div_res_stall),
        .fpu_cpx_req   (fpu_cpx_req),
        .cpx_fpu_grant (cpx_fpu_grant),
        .fpu_cpx_vld   (fpu_cpx_vld),
        .fpu_cpx_id    (fpu_cpx_id),
        .fpu_cpx_data  (fpu_cpx_data),
        .fpu_cpx_exc   (fpu_cpx_exc),
        .fpu_cpx_fcc   (fpu_cpx_fcc)
    );

    // Payload is a function of the ID so the returned packet can be checked whole.
    function automatic logic [63:0] data_of(input logic [4:0] id);
        logic [4:0] d;
        d = id ^ 5'h03;
        return 64'h3FF0_0000_0000_0000 ^ {59'd0, d};
    endfunction

    function automatic logic [4:0] exc_of(input logic [4:0] id);
        return ~id;
    endfunction

    function automatic logic [1:0] fcc_of(input logic [4:0] id);
        return id[1:0];
    endfunction

    typedef struct {
        logic       rst;
        logic [2:0] vld;    // {div, mul, add}
        logic [4:0] ida;
        logic [4:0] idm;
        logic [4:0] idd;
        logic       gnt;
        logic [2:0] stall;  // {div, mul, add}
        logic       req;
        logic       cvld;
        logic [4:0] cid;
    } vec_t;

    localparam int NV = 40;
    vec_t vecs [NV];

    function automatic vec_t mk(input int rst, input int vld, input int ida, input int idm,
                                input int idd, input int gnt, input int st, input int req,
                                input int cv, input int cid);
        vec_t v;
        v.rst   = 1'(rst);
        v.vld   = 3'(vld);
        v.ida   = 5'(ida);
        v.idm   = 5'(idm);
        v.idd   = 5'(idd);
        v.gnt   = 1'(gnt);
        v.stall = 3'(st);
        v.req   = 1'(req);
        v.cvld  = 1'(cv);
        v.cid   = 5'(cid);
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        reset         = v.rst;
        cpx_fpu_grant = v.gnt;
        add_res_vld   = v.vld[0];
        mul_res_vld   = v.vld[1];
        div_res_vld   = v.vld[2];
        add_res_id    = v.ida;
        mul_res_id    = v.idm;
        div_res_id    = v.idd;
        add_res_data  = data_of(v.ida);
        mul_res_data  = data_of(v.idm);
        div_res_data  = data_of(v.idd);
        add_res_exc   = exc_of(v.ida);
        mul_res_exc   = exc_of(v.idm);
        div_res_exc   = exc_of(v.idd);
        add_res_fcc   = fcc_of(v.ida);
        mul_res_fcc   = fcc_of(v.idm);
        div_res_fcc   = fcc_of(v.idd);
    endtask

    initial begin
        //               rst vld   a   m   d  g  stall  req cv cid
        // reset state
        vecs[0]  = mk(1, 'b000, 0,  0,  0, 0, 'b111, 0, 0, 0);
        // single add result, grant tied high
        vecs[1]  = mk(0, 'b001, 3,  0,  0, 1, 'b000, 0, 0, 0);
        vecs[2]  = mk(0, 'b000, 3,  0,  0, 1, 'b000, 1, 0, 0);
        vecs[3]  = mk(0, 'b000, 3,  0,  0, 1, 'b000, 0, 1, 3);
        vecs[4]  = mk(0, 'b000, 3,  0,  0, 0, 'b000, 0, 0, 3);
        // grants on an empty queue
        vecs[5]  = mk(0, 'b000, 3,  0,  0, 1, 'b000, 0, 0, 3);
        vecs[6]  = mk(0, 'b000, 3,  0,  0, 1, 'b000, 0, 0, 3);
        // three pipes at once: div, mul, add order
        vecs[7]  = mk(0, 'b111, 1,  2,  3, 1, 'b011, 0, 0, 3);
        vecs[8]  = mk(0, 'b011, 1,  2,  3, 1, 'b001, 1, 0, 3);
        vecs[9]  = mk(0, 'b001, 1,  2,  3, 1, 'b000, 1, 1, 3);
        vecs[10] = mk(0, 'b000, 1,  2,  3, 1, 'b000, 1, 1, 2);
        vecs[11] = mk(0, 'b000, 1,  2,  3, 1, 'b000, 0, 1, 1);
        vecs[12] = mk(0, 'b000, 1,  2,  3, 0, 'b000, 0, 0, 1);
        // fill to full with grant low, then a single grant pulse
        vecs[13] = mk(0, 'b001, 0,  0,  0, 0, 'b000, 0, 0, 1);
        vecs[14] = mk(0, 'b001, 1,  0,  0, 0, 'b000, 1, 0, 1);
        vecs[15] = mk(0, 'b001, 2,  0,  0, 0, 'b000, 1, 0, 1);
        vecs[16] = mk(0, 'b001, 3,  0,  0, 0, 'b000, 1, 0, 1);
        vecs[17] = mk(0, 'b001, 4,  0,  0, 0, 'b001, 1, 0, 1);
        vecs[18] = mk(0, 'b001, 4,  0,  0, 1, 'b001, 1, 0, 1);
        vecs[19] = mk(0, 'b001, 4,  0,  0, 0, 'b000, 1, 1, 0);
        // full queue with push attempt and grant: stall, occupancy drops to 3
        vecs[20] = mk(0, 'b010, 0,  9,  0, 1, 'b010, 1, 0, 0);
        vecs[21] = mk(0, 'b010, 0,  9,  0, 1, 'b000, 1, 1, 1);
        // ten push+pop cycles wrap the pointers
        vecs[22] = mk(0, 'b100, 0,  9, 10, 1, 'b000, 1, 1, 2);
        vecs[23] = mk(0, 'b100, 0,  9, 11, 1, 'b000, 1, 1, 3);
        vecs[24] = mk(0, 'b100, 0,  9, 12, 1, 'b000, 1, 1, 4);
        vecs[25] = mk(0, 'b100, 0,  9, 13, 1, 'b000, 1, 1, 9);
        vecs[26] = mk(0, 'b100, 0,  9, 14, 1, 'b000, 1, 1, 10);
        vecs[27] = mk(0, 'b100, 0,  9, 15, 1, 'b000, 1, 1, 11);
        vecs[28] = mk(0, 'b100, 0,  9, 16, 1, 'b000, 1, 1, 12);
        vecs[29] = mk(0, 'b100, 0,  9, 17, 1, 'b000, 1, 1, 13);
        vecs[30] = mk(0, 'b100, 0,  9, 18, 1, 'b000, 1, 1, 14);
        vecs[31] = mk(0, 'b100, 0,  9, 19, 1, 'b000, 1, 1, 15);
        // mid-stream reset with three entries queued, push and grant active
        vecs[32] = mk(1, 'b100, 0,  9, 20, 1, 'b111, 1, 1, 16);
        vecs[33] = mk(0, 'b000, 0,  0,  0, 1, 'b000, 0, 0, 0);
        vecs[34] = mk(0, 'b000, 0,  0,  0, 1, 'b000, 0, 0, 0);
        // clean traffic after reset, with a delayed grant
        vecs[35] = mk(0, 'b001, 7,  0,  0, 1, 'b000, 0, 0, 0);
        vecs[36] = mk(0, 'b000, 7,  0,  0, 0, 'b000, 1, 0, 0);
        vecs[37] = mk(0, 'b000, 7,  0,  0, 1, 'b000, 1, 0, 0);
        vecs[38] = mk(0, 'b000, 7,  0,  0, 0, 'b000, 0, 1, 7);
        vecs[39] = mk(0, 'b000, 7,  0,  0, 0, 'b000, 0, 0, 7);

        apply(mk(1, 'b000, 0, 0, 0, 0, 'b111, 0, 0, 0));
        @(posedge rclk);

        for (int i = 0; i < NV; i++) begin
            #1;
            apply(vecs[i]);
            @(negedge rclk);
            chk("add_stall", i, 64'(add_res_stall), 64'(vecs[i].stall[0]));
            chk("mul_stall", i, 64'(mul_res_stall), 64'(vecs[i].stall[1]));
            chk("div_stall", i, 64'(div_res_stall), 64'(vecs[i].stall[2]));
            chk("cpx_req", i, 64'(fpu_cpx_req), 64'(vecs[i].req));
            chk("cpx_vld", i, 64'(fpu_cpx_vld), 64'(vecs[i].cvld));
            chk("cpx_id", i, 64'(fpu_cpx_id), 64'(vecs[i].cid));
            if (vecs[i].cvld) begin
                chk("cpx_data", i, fpu_cpx_data, data_of(vecs[i].cid));
                chk("cpx_exc", i, 64'(fpu_cpx_exc), 64'(exc_of(vecs[i].cid)));
                chk("cpx_fcc", i, 64'(fpu_cpx_fcc), 64'(fcc_of(vecs[i].cid)));
            end else if (vecs[i].cid == 5'd0 && i >= 33 && i <= 37) begin
                // fields are cleared by reset, not merely unqualified
                chk("cpx_data_rst", i, fpu_cpx_data, 64'd0);
            end
            @(posedge rclk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_out_q.md
FPU_OUT_Q -- requirements
Module: fpu_out_q

Interface
REQ-001 Parameter OQ_DEPTH, default 4, number of result entries buffered toward CPX; power of two, minimum 2.
REQ-002 rclk  input  1  global clock; all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 {add,mul,div}_res_vld  input  1 each  pipe p presents a completed result this cycle.
REQ-005 {add,mul,div}_res_id  input  5 each  request ID of the result (the ID captured at FPU input).
REQ-006 {add,mul,div}_res_data  input  64 each  result operand.
REQ-007 {add,mul,div}_res_exc  input  5 each  IEEE exception flags (nv,of,uf,dz,nx).
REQ-008 {add,mul,div}_res_fcc  input  2 each  fcc target of compare results; don't-care otherwise.
REQ-009 {add,mul,div}_res_stall  output  1 each  result not accepted; pipe holds vld and fields unchanged.
REQ-010 fpu_cpx_req  output  1  FPU requests the CPX return path.
REQ-011 cpx_fpu_grant  input  1  CPX grants one packet slot.
REQ-012 fpu_cpx_vld  output  1  packet fields below are valid this cycle.
REQ-013 fpu_cpx_id / _data / _exc / _fcc  output  5/64/5/2  returned packet fields.

Function
REQ-014 At most one result is pushed per cycle; fixed priority div > mul > add among asserted vld inputs.
REQ-015 Push occurs when the winner's vld=1 and the registered occupancy < OQ_DEPTH; the same-cycle pop does not free a slot.
REQ-016 p_res_stall = p_res_vld & ~(pushed from p this cycle); stall is combinational from vld and registered state only, never from cpx_fpu_grant.
REQ-017 Every pipe stall is 1 while reset=1.
REQ-018 Entries leave strictly in push order; no reordering by ID.
REQ-019 fpu_cpx_req = 1 exactly when registered occupancy > 0; req is held until granted.
REQ-020 cpx_fpu_grant=1 in cycle N with occupancy > 0 pops the head; fpu_cpx_vld=1 with head fields in cycle N+1, for exactly one cycle.
REQ-021 A grant with occupancy = 0 is ignored; no pop, fpu_cpx_vld stays 0.
REQ-022 A push and a pop in the same cycle leave occupancy unchanged.
REQ-023 Read and write pointers are log2(OQ_DEPTH) bits wide and wrap modulo OQ_DEPTH. Occupancy is log2(OQ_DEPTH)+1 bits wide and never exceeds OQ_DEPTH or goes below 0.
REQ-024 Minimum latency is vld in N, push at the N edge, req in N+1, grant in N+1, fpu_cpx_vld in N+2.
REQ-025 When fpu_cpx_vld=0, the fpu_cpx_* fields hold their last value (0 after reset); only fpu_cpx_vld is qualifying.
REQ-026 Sustained throughput is one packet per cycle when grant is held high and a result arrives every cycle.

Reset
REQ-027 On a reset edge: occupancy, pointers, fpu_cpx_req, fpu_cpx_vld and all fpu_cpx_* fields become 0. Queued entries are discarded.
REQ-028 Reset asserted mid-stream wins over any same-cycle push, pop or grant. fpu_cpx_vld is 0 in the cycle after the reset edge.
REQ-029 Entry storage contents are not reset; the valid state is carried by occupancy alone.

Structure
REQ-030 The shared package fpu_out_pkg holds the following:
- OQ_DEPTH default
- field widths (ID 5, data 64, exc 5, fcc 2, entry 76)
- pipe-select encoding
REQ-031 One sub-module, fpu_out_fifo, contains the storage, pointers and occupancy. The pipe arbiter, stall logic and CPX handshake live in fpu_out_q.

Verification
REQ-032 add_res_vld=1 with id=5'h03, data=64'h3FF0_0000_0000_0000, grant tied high -> req=1 in cycle 2; fpu_cpx_vld=1 with id 03 and matching data in cycle 3.
REQ-033 add, mul and div vld together in one cycle (ids 01/02/03), grant=1 -> packets in order 03, 02, 01; add stalled 2 cycles, mul stalled 1 cycle.
REQ-034 Grant held 0 with 5 results from add (ids 0-4) -> the first 4 are accepted, add_res_stall=1 on the 5th and req=1 throughout; one grant pulse -> id 0 out, id 4 accepted the cycle after the pop.
REQ-035 Occupancy 4 with a simultaneous push attempt and grant -> stall=1, occupancy becomes 3; ten push/pop cycles with grant=1 wrap the pointers with the ID order preserved.
REQ-036 Grant pulses with the queue empty -> no fpu_cpx_vld. Reset asserted with 3 entries queued and a grant -> the next cycle shows vld=0, req=0, stalls=1 during reset, and no stale packet after reset.
